// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read latency, skid depth and the skid-buffer occupancy encoding.
package fifo_pkg;

    localparam int FIFO_RD_LATENCY = 1;
    localparam int SKID_DEPTH      = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Occupancy as a word count, for credit arithmetic.
    function automatic logic [1:0] occ_words(input occ_e s);
        return s;
    endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Two-entry register skid buffer: head feeds the stream output, tail absorbs the one
// word that can arrive while the head is stalled.
module skid_buf_2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  r_clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output occ_e                  occ
);

    logic [DATA_WIDTH-1:0] tail;

    always_ff @(posedge r_clk) begin
        if (rst) begin
            occ  <= OCC_EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        head <= din;
                        occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail <= din;
                            occ  <= OCC_TWO;
                        end
                        2'b01: occ  <= OCC_EMPTY;
                        2'b11: head <= din;  // just-popped head refilled directly
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    if (pop) begin
                        head <= tail;
                        if (push) tail <= din;
                        else      occ  <= OCC_ONE;
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side front end for the BRAM FIFO: issues fifo_re on credit and presents a bubble-free
// valid/ready stream. Define FIFO_STREAM_READER_CNT_EN to add the rd_count output.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  r_clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic                  fifo_re,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    output logic [15:0]           rd_count
`endif
);

    occ_e       occ;
    logic       inflight;
    logic       pop;
    logic [2:0] credit;

    assign m_valid = (occ != OCC_EMPTY);
    assign pop     = m_valid & m_ready;

    // Slots committed next cycle; pop only happens with occ >= 1, so this never underflows.
    assign credit  = {1'b0, occ_words(occ)} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_re = ~rst & ~fifo_empty & (credit < 3'(SKID_DEPTH));

    always_ff @(posedge r_clk) begin
        if (rst) inflight <= 1'b0;
        else     inflight <= fifo_re;
    end

    skid_buf_2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .r_clk(r_clk),
        .rst  (rst),
        .push (inflight),
        .pop  (pop),
        .din  (fifo_q),
        .head (m_data),
        .occ  (occ)
    );

`ifdef FIFO_STREAM_READER_CNT_EN
    always_ff @(posedge r_clk) begin
        if (rst)      rd_count <= '0;
        else if (pop) rd_count <= rd_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural FIFO model on the read port.
module tb_fifo_stream_reader;

    logic       r_clk;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_q;
    logic       fifo_re;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
`ifdef FIFO_STREAM_READER_CNT_EN
    logic [15:0] rd_count;
`endif

    fifo_stream_reader #(.DATA_WIDTH(8)) dut (
        .r_clk     (r_clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_q    (fifo_q),
        .fifo_re   (fifo_re),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
`ifdef FIFO_STREAM_READER_CNT_EN
        ,
        .rd_count  (rd_count)
`endif
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // FIFO model: 1-cycle read latency, optional generated data for long runs
    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       force_empty = 1'b0;
    logic       gen_mode = 1'b0;

    assign fifo_empty = force_empty | (rd_ptr == wr_ptr);

    always @(posedge r_clk) begin
        if (fifo_re) begin
            fifo_q <= gen_mode ? rd_ptr[7:0] : mem[rd_ptr[9:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    logic [7:0] exp_q [$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pops = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int re_viol = 0;
    logic [7:0] first_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 1024] = 8'(first + i);
            exp_q.push_back(8'(first + i));
            wr_ptr++;
        end
    endtask

    // Negedge sample: scoreboard on every accepted word
    task automatic sample();
        logic [7:0] e;
        @(negedge r_clk);
        if (fifo_re && fifo_empty) re_viol++;
        if (m_valid && m_ready) begin
            if (!gen_mode) begin
                if (exp_q.size() == 0) chk("sb_extra_word", 32'(m_data), 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(m_data), 32'(e));
                end
            end
            pops++;
            if (pops == 1) begin
                first_cyc  = cyc;
                first_data = m_data;
            end
            last_cyc = cyc;
        end
    endtask

    task automatic adv();
        @(posedge r_clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_drained(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            sample();
            adv();
            n++;
        end
        chk("drain_in_budget", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        m_ready = 1'b1;
        load(8'h01, 64);
        adv();

        // Reset holds outputs low even with data available
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("rst_fifo_re", 32'(fifo_re), 32'd0);
            chk("rst_m_valid", 32'(m_valid), 32'd0);
            chk("rst_m_data", 32'(m_data), 32'd0);
            adv();
        end

        // Latency: fifo_re at N, m_valid at N+2
        rst  = 1'b0;
        pops = 0;
        sample();
        chk("first_fifo_re", 32'(fifo_re), 32'd1);
        chk("lat_n0_valid", 32'(m_valid), 32'd0);
        adv();
        sample();
        chk("lat_n1_valid", 32'(m_valid), 32'd0);
        adv();
        sample();
        chk("lat_n2_valid", 32'(m_valid), 32'd1);
        chk("lat_n2_data", 32'(m_data), 32'h01);
        adv();

        // Streaming 64 words, one per cycle
        run_until_drained(200);
        chk("stream_pops", 32'(pops), 32'd64);
        chk("stream_no_bubble", 32'(last_cyc - first_cyc + 1), 32'd64);
        adv();
        sample();
        chk("stream_idle_valid", 32'(m_valid), 32'd0);
        adv();

        // Backpressure: at most two reads, head held
        m_ready = 1'b0;
        load(8'h01, 8);
        begin
            int rd0;
            rd0 = rd_ptr;
            for (int i = 0; i < 6; i++) begin
                sample();
                adv();
            end
            sample();
            chk("bp_reads", 32'(rd_ptr - rd0), 32'd2);
            chk("bp_fifo_re", 32'(fifo_re), 32'd0);
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_m_data", 32'(m_data), 32'h01);
            adv();
        end
        m_ready = 1'b1;
        pops    = 0;
        run_until_drained(40);
        chk("bp_pops", 32'(pops), 32'd8);
        chk("bp_no_gap", 32'(last_cyc - first_cyc + 1), 32'd8);

        // Drain: exactly three words, then idle
        re_viol = 0;
        pops    = 0;
        load(8'h41, 3);
        for (int i = 0; i < 15; i++) begin
            sample();
            adv();
        end
        chk("drain_pops", 32'(pops), 32'd3);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        sample();
        chk("drain_m_valid", 32'(m_valid), 32'd0);
        adv();

        // Forced empty flag blocks reads until released
        force_empty = 1'b1;
        pops        = 0;
        load(8'h44, 4);
        for (int i = 0; i < 5; i++) begin
            sample();
            adv();
        end
        chk("force_empty_pops", 32'(pops), 32'd0);
        force_empty = 1'b0;
        run_until_drained(30);
        chk("force_empty_release_pops", 32'(pops), 32'd4);
        chk("re_while_empty", 32'(re_viol), 32'd0);

        // Mid-stream reset with the buffer full
        m_ready = 1'b0;
        load(8'h51, 8);
        for (int i = 0; i < 5; i++) begin
            sample();
            adv();
        end
        rst = 1'b1;
        sample();
        chk("mrst_fifo_re", 32'(fifo_re), 32'd0);
        adv();
        sample();
        chk("mrst_m_valid", 32'(m_valid), 32'd0);
        adv();
        rst = 1'b0;
        while (exp_q.size() > (wr_ptr - rd_ptr)) void'(exp_q.pop_front());
        m_ready = 1'b1;
        pops    = 0;
        run_until_drained(40);
        chk("mrst_resume_word", 32'(first_data), 32'h53);
        chk("mrst_pops", 32'(pops), 32'd6);

`ifdef FIFO_STREAM_READER_CNT_EN
        // Counter wrap over 65537 accepted words
        rst = 1'b1;
        adv();
        adv();
        rst      = 1'b0;
        gen_mode = 1'b1;
        wr_ptr   = rd_ptr + 65537;
        pops     = 0;
        begin
            int n;
            n = 0;
            while (pops < 65537 && n < 66000) begin
                sample();
                adv();
                n++;
            end
        end
        chk("cnt_pops", 32'(pops), 32'd65537);
        chk("cnt_rd_count", 32'(rd_count), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
